// File: rtl/biquad_capture_pkg.sv
// Shared types and helpers for the biquad capture sequencer.
//   seq_state_t : sequencer state encoding (3 bits)
//   PH_*        : bit/index positions of each timed phase, in execution order
//   next_phase  : first phase after 'cur' whose length is nonzero, else DONE
package biquad_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_GATE = 3'd2,
    S_POST = 3'd3,
    S_FRST = 3'd4,
    S_DONE = 3'd5
  } seq_state_t;

  localparam int PH_PRE  = 0;
  localparam int PH_GATE = 1;
  localparam int PH_POST = 2;
  localparam int PH_FRST = 3;
  localparam int NPHASE  = 4;

  // lens_nz[i] is set when phase i has a nonzero length. Phase i maps to
  // state encoding i+1, so the search starts at the index equal to the
  // current state's encoding (IDLE searches from PRE).
  function automatic seq_state_t next_phase(input seq_state_t cur,
                                            input logic [NPHASE-1:0] lens_nz);
    int start;
    seq_state_t nxt;
    case (cur)
      S_IDLE:  start = PH_PRE;
      S_PRE:   start = PH_GATE;
      S_GATE:  start = PH_POST;
      S_POST:  start = PH_FRST;
      default: start = NPHASE;
    endcase
    nxt = S_DONE;
    // Walk downward so the lowest qualifying phase is the one kept.
    for (int i = NPHASE - 1; i >= 0; i--) begin
      if (i >= start && lens_nz[i]) nxt = seq_state_t'(3'(i + 1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/biquad_capture_fsm.sv
// Capture edge detect, phase sequencer, phase counter, status and capture count.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   capture_i             trigger level; rising edge starts a sequence
//   pre/gate/post/frst_len_i  phase lengths in cycles, latched on acceptance
//   gate_o, filt_rst_o    phase decodes
//   busy_o, done_o, ovr_o status (done/ovr are one-cycle pulses)
//   capture_count_o       accepted trigger count, wrapping
module biquad_capture_fsm
  import biquad_capture_pkg::*;
#(
  parameter int CNTBITS    = 16,
  parameter int CAPCNTBITS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  capture_i,
  input  logic [CNTBITS-1:0]    pre_len_i,
  input  logic [CNTBITS-1:0]    gate_len_i,
  input  logic [CNTBITS-1:0]    post_len_i,
  input  logic [CNTBITS-1:0]    frst_len_i,
  output logic                  gate_o,
  output logic                  filt_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovr_o,
  output logic [CAPCNTBITS-1:0] capture_count_o
);

  typedef logic [NPHASE-1:0][CNTBITS-1:0] lens_t;

  function automatic logic [NPHASE-1:0] nz_mask(input lens_t l);
    logic [NPHASE-1:0] m;
    for (int i = 0; i < NPHASE; i++) m[i] = |l[i];
    return m;
  endfunction

  function automatic logic [CNTBITS-1:0] phase_len(input seq_state_t s, input lens_t l);
    case (s)
      S_PRE:   return l[PH_PRE];
      S_GATE:  return l[PH_GATE];
      S_POST:  return l[PH_POST];
      S_FRST:  return l[PH_FRST];
      default: return '0;
    endcase
  endfunction

  seq_state_t         state_q, state_d;
  logic [CNTBITS-1:0] cnt_q, cnt_d;
  lens_t              len_q, lens_in;
  logic               cap_q;
  logic               cap_edge;

  always_comb begin
    lens_in          = '0;
    lens_in[PH_PRE]  = pre_len_i;
    lens_in[PH_GATE] = gate_len_i;
    lens_in[PH_POST] = post_len_i;
    lens_in[PH_FRST] = frst_len_i;
  end

  assign cap_edge = capture_i & ~cap_q;

  // Next state and counter load. A phase is entered with len-1 and left
  // when the count reaches 0, so it spans exactly len cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cap_edge) begin
          state_d = next_phase(S_IDLE, nz_mask(lens_in));
          cnt_d   = (state_d == S_DONE) ? '0 : phase_len(state_d, lens_in) - CNTBITS'(1);
        end
      end
      S_PRE, S_GATE, S_POST, S_FRST: begin
        if (cnt_q == '0) begin
          state_d = next_phase(state_q, nz_mask(len_q));
          cnt_d   = (state_d == S_DONE) ? '0 : phase_len(state_d, len_q) - CNTBITS'(1);
        end else begin
          cnt_d = cnt_q - CNTBITS'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register without any input-to-output combinational path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      cap_q           <= 1'b1;  // a level held through reset is not an edge
      len_q           <= '0;
      capture_count_o <= '0;
      gate_o          <= 1'b0;
      filt_rst_o      <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      ovr_o           <= 1'b0;
    end else begin
      cap_q      <= capture_i;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gate_o     <= (state_d == S_GATE);
      filt_rst_o <= (state_d == S_FRST);
      busy_o     <= (state_d != S_IDLE);
      done_o     <= (state_d == S_DONE);
      ovr_o      <= cap_edge && (state_q != S_IDLE);
      if (cap_edge && state_q == S_IDLE) begin
        len_q           <= lens_in;
        capture_count_o <= capture_count_o + CAPCNTBITS'(1);
      end
    end
  end

endmodule

// File: rtl/biquad_capture_sequencer.sv
// Capture-gate and filter-reset sequencer for multi-channel biquad test rigs.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   capture_i           trigger level (rising edge starts a sequence)
//   *_len_i             pre-delay, gate, post-delay, filter-reset lengths
//   dat_i / dat_o       NCHAN x NSAMP x NBITS packed samples in / gated out
//   gate_o, filt_rst_o  gate window and downstream filter reset
//   busy_o, done_o, ovr_o, capture_count_o  status
module biquad_capture_sequencer
  import biquad_capture_pkg::*;
#(
  parameter int NCHAN      = 2,
  parameter int NSAMP      = 8,
  parameter int NBITS      = 12,
  parameter int CNTBITS    = 16,
  parameter int CAPCNTBITS = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         capture_i,
  input  logic [CNTBITS-1:0]           pre_len_i,
  input  logic [CNTBITS-1:0]           gate_len_i,
  input  logic [CNTBITS-1:0]           post_len_i,
  input  logic [CNTBITS-1:0]           frst_len_i,
  input  logic [NCHAN*NSAMP*NBITS-1:0] dat_i,
  output logic [NCHAN*NSAMP*NBITS-1:0] dat_o,
  output logic                         gate_o,
  output logic                         filt_rst_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         ovr_o,
  output logic [CAPCNTBITS-1:0]        capture_count_o
);

  localparam int CW = NSAMP * NBITS;

  biquad_capture_fsm #(
    .CNTBITS    (CNTBITS),
    .CAPCNTBITS (CAPCNTBITS)
  ) u_fsm (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .capture_i       (capture_i),
    .pre_len_i       (pre_len_i),
    .gate_len_i      (gate_len_i),
    .post_len_i      (post_len_i),
    .frst_len_i      (frst_len_i),
    .gate_o          (gate_o),
    .filt_rst_o      (filt_rst_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .ovr_o           (ovr_o),
    .capture_count_o (capture_count_o)
  );

  // Stage p1: gated sample register, one per channel; samples pass bit-exact.
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    logic [CW-1:0] dat_p1;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) dat_p1 <= '0;
      else       dat_p1 <= gate_o ? dat_i[c*CW +: CW] : '0;
    end
    assign dat_o[c*CW +: CW] = dat_p1;
  end

endmodule

// File: tb/tb_biquad_capture_sequencer.sv
module tb_biquad_capture_sequencer;

  localparam int NCHAN = 2, NSAMP = 8, NBITS = 12, CNTBITS = 16, CAPCNTBITS = 8;
  localparam int W = NCHAN * NSAMP * NBITS;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               capture = 1'b0;
  logic               cap_w = 1'b0;
  logic [CNTBITS-1:0] pre_len = '0, gate_len = '0, post_len = '0, frst_len = '0;
  logic [CNTBITS-1:0] zero_len = '0;
  logic [W-1:0]       dat_i = '0;

  logic [W-1:0]            dat_o, dat_o_w;
  logic                    gate_o, filt_rst_o, busy_o, done_o, ovr_o;
  logic                    gate_w, filt_w, busy_w, done_w, ovr_w;
  logic [CAPCNTBITS-1:0]   count_o;
  logic [1:0]              count_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  biquad_capture_sequencer #(
    .NCHAN(NCHAN), .NSAMP(NSAMP), .NBITS(NBITS), .CNTBITS(CNTBITS), .CAPCNTBITS(CAPCNTBITS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .capture_i(capture),
    .pre_len_i(pre_len), .gate_len_i(gate_len), .post_len_i(post_len), .frst_len_i(frst_len),
    .dat_i(dat_i), .dat_o(dat_o), .gate_o(gate_o), .filt_rst_o(filt_rst_o),
    .busy_o(busy_o), .done_o(done_o), .ovr_o(ovr_o), .capture_count_o(count_o)
  );

  // Narrow counter instance for the wrap scenario; all phases zero-length.
  biquad_capture_sequencer #(
    .NCHAN(NCHAN), .NSAMP(NSAMP), .NBITS(NBITS), .CNTBITS(CNTBITS), .CAPCNTBITS(2)
  ) dut_w (
    .clk_i(clk), .rst_i(rst), .capture_i(cap_w),
    .pre_len_i(zero_len), .gate_len_i(zero_len), .post_len_i(zero_len), .frst_len_i(zero_len),
    .dat_i(dat_i), .dat_o(dat_o_w), .gate_o(gate_w), .filt_rst_o(filt_w),
    .busy_o(busy_w), .done_o(done_w), .ovr_o(ovr_w), .capture_count_o(count_w)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic set_lens(input int p, input int g, input int q, input int f);
    pre_len  = CNTBITS'(p);
    gate_len = CNTBITS'(g);
    post_len = CNTBITS'(q);
    frst_len = CNTBITS'(f);
  endtask

  // Leaves the bench 1 time unit after a rising edge; that interval is cycle 0.
  task automatic do_reset();
    rst = 1'b1; capture = 1'b0; cap_w = 1'b0; dat_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; capture = 1'b0; dat_i = '1;
    set_lens(3, 4, 2, 5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if ({gate_o, filt_rst_o, busy_o, done_o, ovr_o} !== 5'b0) begin
      n_err++; $display("FAIL reset_status got %b required 00000", {gate_o, filt_rst_o, busy_o, done_o, ovr_o}); end
    n_vec++; if (count_o !== 8'd0) begin
      n_err++; $display("FAIL reset_count got %0d required 0", count_o); end
    n_vec++; if (count_w !== 2'd0) begin
      n_err++; $display("FAIL reset_count_w got %0d required 0", count_w); end
    n_vec++; if (dat_o !== '0) begin
      n_err++; $display("FAIL reset_dat got %h required 0", dat_o); end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++; if (dat_o !== '0 || busy_o !== 1'b0) begin
        n_err++; $display("FAIL idle_after_reset k=%0d dat=%h busy=%b required 0/0", k, dat_o, busy_o); end
      @(posedge clk); #1;
    end
    dat_i = '0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_cnt;
    set_lens(3, 4, 2, 5);
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      capture = (k == 10);
      @(negedge clk);
      exp_cnt = (k >= 11) ? 8'd1 : 8'd0;
      n_vec++; if (gate_o !== (k >= 14 && k <= 17)) begin
        n_err++; $display("FAIL basic_gate cyc=%0d got %b", k, gate_o); end
      n_vec++; if (filt_rst_o !== (k >= 20 && k <= 24)) begin
        n_err++; $display("FAIL basic_frst cyc=%0d got %b", k, filt_rst_o); end
      n_vec++; if (done_o !== (k == 25)) begin
        n_err++; $display("FAIL basic_done cyc=%0d got %b", k, done_o); end
      n_vec++; if (busy_o !== (k >= 11 && k <= 25)) begin
        n_err++; $display("FAIL basic_busy cyc=%0d got %b", k, busy_o); end
      n_vec++; if (count_o !== exp_cnt) begin
        n_err++; $display("FAIL basic_count cyc=%0d got %0d required %0d", k, count_o, exp_cnt); end
      n_vec++; if (ovr_o !== 1'b0) begin
        n_err++; $display("FAIL basic_ovr cyc=%0d got %b required 0", k, ovr_o); end
      @(posedge clk); #1;
    end
  endtask

  // dat_i in cycle k carries the index of the previous cycle (k-1), replicated.
  task automatic test_data_gating();
    logic [NBITS-1:0] dv;
    logic [W-1:0]     exp_dat;
    set_lens(3, 4, 2, 5);
    do_reset();
    for (int k = 0; k <= 26; k++) begin
      capture = (k == 10);
      dv = (k == 0) ? '0 : NBITS'(k - 1);
      dat_i = {(NCHAN * NSAMP){dv}};
      @(negedge clk);
      dv = NBITS'(k - 2);
      exp_dat = (k >= 15 && k <= 18) ? {(NCHAN * NSAMP){dv}} : '0;
      n_vec++; if (dat_o !== exp_dat) begin
        n_err++; $display("FAIL data_gate cyc=%0d got %h required %h", k, dat_o, exp_dat); end
      @(posedge clk); #1;
    end
    dat_i = '0;
  endtask

  task automatic test_zero_lengths();
    set_lens(0, 2, 0, 0);
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      capture = (k == 5);
      @(negedge clk);
      n_vec++; if (gate_o !== (k >= 6 && k <= 7)) begin
        n_err++; $display("FAIL zero_gate cyc=%0d got %b", k, gate_o); end
      n_vec++; if (done_o !== (k == 8)) begin
        n_err++; $display("FAIL zero_done cyc=%0d got %b", k, done_o); end
      n_vec++; if (busy_o !== (k >= 6 && k <= 8)) begin
        n_err++; $display("FAIL zero_busy cyc=%0d got %b", k, busy_o); end
      @(posedge clk); #1;
    end
    set_lens(0, 0, 0, 0);
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      capture = (k == 5);
      @(negedge clk);
      n_vec++; if (done_o !== (k == 6)) begin
        n_err++; $display("FAIL allzero_done cyc=%0d got %b", k, done_o); end
      n_vec++; if (gate_o !== 1'b0 || filt_rst_o !== 1'b0) begin
        n_err++; $display("FAIL allzero_gate cyc=%0d got %b%b required 00", k, gate_o, filt_rst_o); end
      n_vec++; if (busy_o !== (k == 6)) begin
        n_err++; $display("FAIL allzero_busy cyc=%0d got %b", k, busy_o); end
      @(posedge clk); #1;
    end
  endtask

  // Second edge lands in GATE; lengths are also changed mid-run.
  task automatic test_overrun();
    logic [7:0] exp_cnt;
    set_lens(3, 4, 2, 5);
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      capture = (k == 10 || k == 15);
      if (k == 12) set_lens(1, 1, 1, 1);
      @(negedge clk);
      exp_cnt = (k >= 11) ? 8'd1 : 8'd0;
      n_vec++; if (ovr_o !== (k == 16)) begin
        n_err++; $display("FAIL ovr_pulse cyc=%0d got %b", k, ovr_o); end
      n_vec++; if (gate_o !== (k >= 14 && k <= 17)) begin
        n_err++; $display("FAIL ovr_gate cyc=%0d got %b", k, gate_o); end
      n_vec++; if (filt_rst_o !== (k >= 20 && k <= 24)) begin
        n_err++; $display("FAIL ovr_frst cyc=%0d got %b", k, filt_rst_o); end
      n_vec++; if (done_o !== (k == 25)) begin
        n_err++; $display("FAIL ovr_done cyc=%0d got %b", k, done_o); end
      n_vec++; if (count_o !== exp_cnt) begin
        n_err++; $display("FAIL ovr_count cyc=%0d got %0d required %0d", k, count_o, exp_cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    set_lens(3, 4, 2, 5);
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      capture = (k >= 10);
      @(posedge clk); #1;
    end
    // Now in cycle 21, inside the filter-reset phase.
    n_vec++; if (filt_rst_o !== 1'b1) begin
      n_err++; $display("FAIL midop_in_frst got %b required 1", filt_rst_o); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({gate_o, filt_rst_o, busy_o, done_o, ovr_o} !== 5'b0) begin
      n_err++; $display("FAIL midop_async_clear got %b required 00000", {gate_o, filt_rst_o, busy_o, done_o, ovr_o}); end
    n_vec++; if (count_o !== 8'd0 || dat_o !== '0) begin
      n_err++; $display("FAIL midop_count_dat got count %0d dat %h required 0/0", count_o, dat_o); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_vec++; if (busy_o !== 1'b0 || done_o !== 1'b0 || count_o !== 8'd0) begin
        n_err++; $display("FAIL midop_held_level k=%0d busy=%b done=%b count=%0d required 0/0/0", k, busy_o, done_o, count_o); end
      @(posedge clk); #1;
    end
    capture = 1'b0;
    @(posedge clk); #1;
    capture = 1'b1;
    @(negedge clk);
    n_vec++; if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL midop_edge_cycle got busy %b required 0", busy_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (busy_o !== 1'b1 || count_o !== 8'd1) begin
      n_err++; $display("FAIL midop_retrigger got busy %b count %0d required 1/1", busy_o, count_o); end
    capture = 1'b0;
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w;
    do_reset();
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      cap_w = 1'b1;
      @(posedge clk); #1;
      cap_w = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      exp_w = 2'(i + 1);
      n_vec++; if (count_w !== exp_w) begin
        n_err++; $display("FAIL wrap_count trig=%0d got %0d required %0d", i + 1, count_w, exp_w); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_data_gating();
    test_zero_lengths();
    test_overrun();
    test_reset_midop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
